// File: rtl/pulse_inject_pkg.sv
// Shared types and arithmetic helpers for the matched pulse injector.
package pulse_inject_pkg;

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  // Signed add clamped to the range of a w-bit two's-complement sample.
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/inject_sat_add.sv
// One output lane: registered saturating sum of a sample and a gain-scaled template word.
module inject_sat_add
  import pulse_inject_pkg::*;
#(
  parameter int INBITS = 12
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic signed [INBITS-1:0] smp,
  input  logic signed [INBITS-1:0] tmpl,
  input  logic        [1:0]        gain,
  output logic signed [INBITS-1:0] sum
);

  // Second latency stage: scale template, add, saturate, register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sum <= '0;
    end else begin
      sum <= INBITS'(sat_add(int'(smp), int'(tmpl >>> gain), INBITS));
    end
  end

endmodule

// File: rtl/matched_pulse_injector.sv
// Plays a stored impulse template into the parallel sample stream at a chosen
// lane phase and gain; a fixed two-clock passthrough when not playing.
module matched_pulse_injector
  import pulse_inject_pkg::*;
#(
  parameter int INBITS   = 12,
  parameter int NSAMP    = 8,
  parameter int TMPL_LEN = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NSAMP*INBITS-1:0]     data_i,
  output logic [NSAMP*INBITS-1:0]     data_o,
  input  logic                        trig_valid_i,
  output logic                        trig_ready_o,
  input  logic [$clog2(NSAMP)-1:0]    trig_phase_i,
  input  logic [1:0]                  trig_gain_i,
  input  logic                        tmpl_wr_i,
  input  logic [$clog2(TMPL_LEN)-1:0] tmpl_addr_i,
  input  logic signed [INBITS-1:0]    tmpl_dat_i,
  output logic                        busy_o,
  output logic                        wr_drop_o
);

  localparam int PW    = $clog2(NSAMP);
  localparam int AW    = $clog2(TMPL_LEN);
  localparam int NWORD = TMPL_LEN / NSAMP;
  localparam int BW    = $clog2(NWORD + 1);

  state_t                   state, state_nxt;
  logic [BW-1:0]            beat, beat_nxt, last_beat;
  logic [PW-1:0]            phase_q, phase_nxt;
  logic [1:0]               gain_q, gain_nxt;
  logic                     accept;
  logic                     wr_ok;

  logic signed [INBITS-1:0] mem    [TMPL_LEN];
  logic signed [INBITS-1:0] win    [2*NSAMP];
  logic signed [INBITS-1:0] lane_t [NSAMP];
  logic signed [INBITS-1:0] smp1   [NSAMP];
  logic signed [INBITS-1:0] tmpl1  [NSAMP];
  logic        [1:0]        gain1;

  assign trig_ready_o = aresetn && (state == IDLE);
  assign accept       = trig_valid_i && trig_ready_o;
  assign wr_ok        = tmpl_wr_i && trig_ready_o && !accept;
  assign busy_o       = (state == PLAY);
  // A nonzero phase spills the template tail into one extra beat.
  assign last_beat    = (phase_q != '0) ? BW'(NWORD) : BW'(NWORD - 1);

  // Control state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      beat    <= '0;
      phase_q <= '0;
      gain_q  <= '0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      phase_q <= phase_nxt;
      gain_q  <= gain_nxt;
    end
  end

  // Next-state: accept a trigger in IDLE, step beats in PLAY.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    phase_nxt = phase_q;
    gain_nxt  = gain_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PLAY;
          beat_nxt  = '0;
          phase_nxt = trig_phase_i;
          gain_nxt  = trig_gain_i;
        end
      end
      PLAY: begin
        if (beat == last_beat) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky flag for template writes refused while playing or on the accept cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_drop_o <= 1'b0;
    end else if (tmpl_wr_i && !wr_ok) begin
      wr_drop_o <= 1'b1;
    end
  end

  // Template store write port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_ok) begin
      mem[tmpl_addr_i] <= tmpl_dat_i;
    end
  end

  // Window = template words beat-1 and beat; out-of-range positions read as zero.
  for (genvar i = 0; i < 2*NSAMP; i++) begin : g_win
    logic [31:0] base;
    logic        in_rng;
    assign base   = 32'(beat) * 32'(NSAMP) + 32'(i);
    assign in_rng = (base >= 32'(NSAMP)) && (base < 32'(TMPL_LEN + NSAMP));
    assign win[i] = in_rng ? mem[AW'(base - 32'(NSAMP))] : '0;
  end

  // Lane j takes window position NSAMP+j-phase, i.e. template index beat*NSAMP+j-phase.
  for (genvar j = 0; j < NSAMP; j++) begin : g_lane
    logic [PW:0] sel;
    assign sel       = (PW+1)'(NSAMP + j) - {1'b0, phase_q};
    assign lane_t[j] = win[sel];

    inject_sat_add #(.INBITS(INBITS)) u_add (
      .aclk    (aclk),
      .aresetn (aresetn),
      .smp     (smp1[j]),
      .tmpl    (tmpl1[j]),
      .gain    (gain1),
      .sum     (data_o[j*INBITS +: INBITS])
    );
  end

  // First latency stage: capture samples and the registered template read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      smp1  <= '{default: '0};
      tmpl1 <= '{default: '0};
      gain1 <= '0;
    end else begin
      for (int unsigned j = 0; j < NSAMP; j++) begin
        smp1[j]  <= data_i[j*INBITS +: INBITS];
        tmpl1[j] <= busy_o ? lane_t[j] : '0;
      end
      gain1 <= gain_q;
    end
  end

endmodule

// File: tb/tb_matched_pulse_injector.sv
// Randomised and directed bench for matched_pulse_injector against a
// behavioural model of template placement, gain and saturation.
module tb_matched_pulse_injector;

  localparam int N  = 8;
  localparam int IB = 12;
  localparam int TL = 32;
  localparam int W  = N * IB;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [W-1:0] data_i;
  logic [W-1:0] data_o;
  logic         trig_valid_i;
  logic         trig_ready_o;
  logic [2:0]   trig_phase_i;
  logic [1:0]   trig_gain_i;
  logic         tmpl_wr_i;
  logic [4:0]   tmpl_addr_i;
  logic [11:0]  tmpl_dat_i;
  logic         busy_o;
  logic         wr_drop_o;

  matched_pulse_injector #(.INBITS(IB), .NSAMP(N), .TMPL_LEN(TL)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .data_i       (data_i),
    .data_o       (data_o),
    .trig_valid_i (trig_valid_i),
    .trig_ready_o (trig_ready_o),
    .trig_phase_i (trig_phase_i),
    .trig_gain_i  (trig_gain_i),
    .tmpl_wr_i    (tmpl_wr_i),
    .tmpl_addr_i  (tmpl_addr_i),
    .tmpl_dat_i   (tmpl_dat_i),
    .busy_o       (busy_o),
    .wr_drop_o    (wr_drop_o)
  );

  always #5 aclk = ~aclk;

  // Reference state
  int           m_tmpl [TL];
  bit           m_busy;
  int           m_beat, m_nbeat, m_p, m_g;
  bit           m_drop;
  logic [W-1:0] exp_s1, exp_o;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] r;
    for (int j = 0; j < N; j++) r[j*IB +: IB] = v[IB-1:0];
    return r;
  endfunction

  task automatic compare_outputs();
    chk("data_o",  data_o, exp_o);
    chk("busy",    W'(busy_o), W'(m_busy));
    chk("ready",   W'(trig_ready_o), W'(!m_busy));
    chk("wr_drop", W'(wr_drop_o), W'(m_drop));
  endtask

  // Apply one cycle of inputs and advance the model across the coming edge.
  task automatic drive_and_model(input logic [W-1:0] d, input bit v, input int p, input int g,
                                 input bit w, input int a, input int td);
    logic [W-1:0] s;
    int x, inj, k, sum;
    bit acc;
    data_i       = d;
    trig_valid_i = v;
    trig_phase_i = 3'(p);
    trig_gain_i  = 2'(g);
    tmpl_wr_i    = w;
    tmpl_addr_i  = 5'(a);
    tmpl_dat_i   = td[11:0];
    for (int j = 0; j < N; j++) begin
      x   = int'($signed(d[j*IB +: IB]));
      inj = 0;
      if (m_busy) begin
        k = m_beat * N + j - m_p;
        if (k >= 0 && k < TL) inj = m_tmpl[k] >>> m_g;
      end
      sum = x + inj;
      if (sum > 2047)  sum = 2047;
      if (sum < -2048) sum = -2048;
      s[j*IB +: IB] = sum[IB-1:0];
    end
    exp_o  = exp_s1;
    exp_s1 = s;
    acc = v && !m_busy;
    if (w) begin
      if (!m_busy && !acc) m_tmpl[a] = td;
      else                 m_drop = 1'b1;
    end
    if (m_busy) begin
      m_beat++;
      if (m_beat == m_nbeat) m_busy = 1'b0;
    end else if (acc) begin
      m_busy  = 1'b1;
      m_beat  = 0;
      m_p     = p;
      m_g     = g;
      m_nbeat = TL / N + ((p != 0) ? 1 : 0);
    end
  endtask

  task automatic tick(input logic [W-1:0] d, input bit v, input int p, input int g,
                      input bit w, input int a, input int td);
    @(negedge aclk);
    compare_outputs();
    drive_and_model(d, v, p, g, w, a, td);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic fill_tmpl(input int v);
    for (int a = 0; a < TL; a++) tick('0, 1'b0, 0, 0, 1'b1, a, v);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_data",  data_o, '0);
    chk("rst_busy",  W'(busy_o), '0);
    chk("rst_drop",  W'(wr_drop_o), '0);
    chk("rst_ready", W'(trig_ready_o), '0);
    m_busy = 1'b0;
    m_drop = 1'b0;
    exp_s1 = '0;
    exp_o  = '0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rel_ready", W'(trig_ready_o), W'(1));
    drive_and_model('0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    logic [W-1:0] d;
    aresetn      = 1'b0;
    data_i       = '0;
    trig_valid_i = 1'b0;
    trig_phase_i = '0;
    trig_gain_i  = '0;
    tmpl_wr_i    = 1'b0;
    tmpl_addr_i  = '0;
    tmpl_dat_i   = '0;
    m_busy = 1'b0;
    m_drop = 1'b0;
    exp_s1 = '0;
    exp_o  = '0;
    do_reset();
    fill_tmpl(0);

    // Passthrough ramp
    for (int c = 0; c < 10; c++) begin
      for (int j = 0; j < N; j++) d[j*IB +: IB] = 12'(16 * c + j);
      tick(d, 1'b0, 0, 0, 1'b0, 0, 0);
    end

    // Single impulse at phase 0, unity gain
    tick('0, 1'b0, 0, 0, 1'b1, 0, 100);
    tick('0, 1'b1, 0, 0, 1'b0, 0, 0);
    idle(7);

    // Phase 5, gain 1, tail sample spills into a fifth beat
    tick('0, 1'b0, 0, 0, 1'b1, 31, 7);
    tick('0, 1'b1, 5, 1, 1'b0, 0, 0);
    idle(8);

    // Positive and negative saturation
    fill_tmpl(100);
    tick(rep(2000), 1'b1, 0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) tick(rep(2000), 1'b0, 0, 0, 1'b0, 0, 0);
    fill_tmpl(-100);
    tick(rep(-2000), 1'b1, 0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) tick(rep(-2000), 1'b0, 0, 0, 1'b0, 0, 0);

    // Writes during play are dropped; held trigger is taken on the first idle cycle
    fill_tmpl(0);
    tick('0, 1'b0, 0, 0, 1'b1, 3, 55);
    tick('0, 1'b1, 0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) tick('0, 1'b1, 0, 0, 1'b1, 3, -9);
    idle(6);
    tick('0, 1'b1, 0, 2, 1'b0, 0, 0);
    idle(7);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom, $urandom};
      tick(d, ($urandom_range(3) == 0), int'($urandom_range(7)), int'($urandom_range(3)),
           ($urandom_range(3) == 0), int'($urandom_range(TL - 1)),
           int'($urandom_range(4095)) - 2048);
    end
    idle(8);

    // Reset in the middle of a play: nothing may leak out afterwards
    tick('0, 1'b1, 3, 0, 1'b0, 0, 0);
    tick({$urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) tick({$urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b0, 0, 0);
    tick('0, 1'b1, 1, 1, 1'b0, 0, 0);
    idle(7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
